uart_frame_decoder: RTL and testbench

Assembles position frames from the UART receiver's byte stream into the ball and player-2 paddle coordinates consumed by the player-2 source multiplexer (`*_uart` inputs). It sits between the UART RX byte interface and the mux. It validates framing, reserved bits, checksum and coordinate range. All three outputs update together in one cycle, only on a fully valid frame. It also reports per-frame status and a link-alive flag.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/uart_link_monitor.sv | 45 ++++
 rtl/uart_frame_decoder.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry plus the UART position-frame layout used by both the
// receive-side decoder and the transmit-side encoder.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 640;
  localparam int unsigned VER_PIXELS = 480;
  localparam int unsigned BALLSIZE   = 10;
  localparam int unsigned PAD_HEIGHT = 80;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  // Largest coordinates that keep the ball / paddle fully on screen.
  localparam int unsigned X_MAX = HOR_PIXELS - BALLSIZE;
  localparam int unsigned Y_MAX = VER_PIXELS - BALLSIZE;
  localparam int unsigned P_MAX = VER_PIXELS - PAD_HEIGHT;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 8;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } uart_frame_state_t;

endpackage

// File: rtl/uart_link_monitor.sv
// Link-alive tracker: link_up rises on a commit and falls once LINK_TIMEOUT
// cycles pass without another commit.
//   clk, rst : clock, synchronous active-high reset
//   commit   : one-cycle strobe for each accepted frame
//   link_up  : registered link-alive flag
module uart_link_monitor #(
  parameter int unsigned LINK_TIMEOUT = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic commit,
  output logic link_up
);

  localparam int unsigned LC_W = $clog2(LINK_TIMEOUT + 1);

  logic [LC_W-1:0] cnt_q, cnt_d;
  logic            up_q, up_d;

  // Saturating idle counter; link drops the cycle the counter hits the limit.
  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (commit) begin
      cnt_d = '0;
      up_d  = 1'b1;
    end else begin
      if (cnt_q != LC_W'(LINK_TIMEOUT)) cnt_d = cnt_q + LC_W'(1);
      if (cnt_d == LC_W'(LINK_TIMEOUT)) up_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      up_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      up_q  <= up_d;
    end
  end

  assign link_up = up_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Turns the UART RX byte stream into ball / player-2 paddle coordinates.
// Frames are A5, x_hi, x_lo, y_hi, y_lo, p_hi, p_lo, xor(B1..B6); a frame is
// committed to all three outputs at once only if every check passes.
//   clk, rst        : clock, synchronous active-high reset
//   rx_data/rx_valid: received byte and its one-cycle strobe
//   x_ball_uart, y_ball_uart, y_player2_uart : committed coordinates
//   frame_ok / frame_err : one-cycle commit / reject pulses
//   link_up         : high while valid frames keep arriving
module uart_frame_decoder
  import vga_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 100_000,
  parameter int unsigned LINK_TIMEOUT = 6_500_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [X_W-1:0] x_ball_uart,
  output logic [Y_W-1:0] y_ball_uart,
  output logic [Y_W-1:0] y_player2_uart,
  output logic           frame_ok,
  output logic           frame_err,
  output logic           link_up
);

  localparam int unsigned BT_W     = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned IDX_W    = $clog2(FRAME_BYTES);
  localparam int unsigned LAST_IDX = FRAME_BYTES - 3;  // index of B6

  uart_frame_state_t state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              rsv_q, rsv_d;
  logic [BT_W-1:0]   bcnt_q, bcnt_d;
  logic [X_W-1:0]    x_sh_q, x_sh_d, x_q, x_d;
  logic [Y_W-1:0]    y_sh_q, y_sh_d, y_q, y_d;
  logic [Y_W-1:0]    p_sh_q, p_sh_d, p_q, p_d;
  logic              ok_q, ok_d, err_q, err_d;
  logic              commit_c, range_ok_c, byte_to_c;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    rsv_d    = rsv_q;
    bcnt_d   = bcnt_q;
    x_sh_d   = x_sh_q;
    y_sh_d   = y_sh_q;
    p_sh_d   = p_sh_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    commit_c = 1'b0;

    range_ok_c = (x_sh_q <= 11'(X_MAX)) &&
                 ({1'b0, y_sh_q} <= 11'(Y_MAX)) &&
                 ({1'b0, p_sh_q} <= 11'(P_MAX));

    // A byte arriving in the expiry cycle wins over the timeout.
    byte_to_c = (state_q != HUNT) && !rx_valid &&
                (bcnt_q == BT_W'(BYTE_TIMEOUT - 1));

    if (state_q == HUNT || rx_valid) bcnt_d = '0;
    else                             bcnt_d = bcnt_q + BT_W'(1);

    case (state_q)
      HUNT: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = RECV;
          idx_d   = '0;
          csum_d  = '0;
          rsv_d   = 1'b0;
        end
      end

      RECV: begin
        if (byte_to_c) begin
          err_d   = 1'b1;
          state_d = HUNT;
          bcnt_d  = '0;
        end else if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + IDX_W'(1);
          case (idx_q)
            IDX_W'(0): begin
              x_sh_d[10:8] = rx_data[2:0];
              rsv_d        = rsv_q | (rx_data[7:3] != 5'd0);
            end
            IDX_W'(1): x_sh_d[7:0] = rx_data;
            IDX_W'(2): begin
              y_sh_d[9:8] = rx_data[1:0];
              rsv_d       = rsv_q | (rx_data[7:2] != 6'd0);
            end
            IDX_W'(3): y_sh_d[7:0] = rx_data;
            IDX_W'(4): begin
              p_sh_d[9:8] = rx_data[1:0];
              rsv_d       = rsv_q | (rx_data[7:2] != 6'd0);
            end
            default:   p_sh_d[7:0] = rx_data;
          endcase
          if (idx_q == IDX_W'(LAST_IDX)) state_d = CHECK;
        end
      end

      CHECK: begin
        if (byte_to_c) begin
          err_d   = 1'b1;
          state_d = HUNT;
          bcnt_d  = '0;
        end else if (rx_valid) begin
          state_d = HUNT;
          if (rx_data == csum_q && !rsv_q && range_ok_c) begin
            x_d      = x_sh_q;
            y_d      = y_sh_q;
            p_d      = p_sh_q;
            ok_d     = 1'b1;
            commit_c = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      idx_q   <= '0;
      csum_q  <= '0;
      rsv_q   <= 1'b0;
      bcnt_q  <= '0;
      x_sh_q  <= '0;
      y_sh_q  <= '0;
      p_sh_q  <= '0;
      x_q     <= X_W'(X_MAX / 2);
      y_q     <= Y_W'(Y_MAX / 2);
      p_q     <= Y_W'(P_MAX / 2);
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      rsv_q   <= rsv_d;
      bcnt_q  <= bcnt_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      p_sh_q  <= p_sh_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  uart_link_monitor #(
    .LINK_TIMEOUT (LINK_TIMEOUT)
  ) u_link (
    .clk     (clk),
    .rst     (rst),
    .commit  (commit_c),
    .link_up (link_up)
  );

  assign x_ball_uart    = x_q;
  assign y_ball_uart    = y_q;
  assign y_player2_uart = p_q;
  assign frame_ok       = ok_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with short byte / link timeouts.
// Geometry: 640x480, ball 10, paddle 80 -> limits x<=630, y<=470, p<=400,
// reset centre 315/235/200.
module tb_uart_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] x_ball_uart;
  logic [9:0]  y_ball_uart;
  logic [9:0]  y_player2_uart;
  logic        frame_ok;
  logic        frame_err;
  logic        link_up;

  int checks = 0;
  int passes = 0;

  uart_frame_decoder #(
    .BYTE_TIMEOUT (16),
    .LINK_TIMEOUT (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .x_ball_uart    (x_ball_uart),
    .y_ball_uart    (y_ball_uart),
    .y_player2_uart (y_player2_uart),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .link_up        (link_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Sends the 8 bytes MSB first; returns just after the checksum is registered.
  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8]);
  endtask

  task automatic check_xyp(input string tag, input int x, input int y, input int p);
    check({tag, ".x"}, 32'(x_ball_uart), 32'(x));
    check({tag, ".y"}, 32'(y_ball_uart), 32'(y));
    check({tag, ".p"}, 32'(y_player2_uart), 32'(p));
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(2);
    rst = 1'b0;

    // Reset state
    check_xyp("reset", 315, 235, 200);
    check("reset.ok",   32'(frame_ok),  0);
    check("reset.err",  32'(frame_err), 0);
    check("reset.link", 32'(link_up),   0);

    // x=400 y=200 p=100; checksum 01^90^00^C8^00^64 = 3D
    send_frame(64'hA5_01_90_00_C8_00_64_3D);
    check_xyp("good", 400, 200, 100);
    check("good.ok",   32'(frame_ok),  1);
    check("good.err",  32'(frame_err), 0);
    check("good.link", 32'(link_up),   1);
    tick(1);
    check("good.ok_pulse", 32'(frame_ok), 0);

    // Wrong checksum, sent back to back
    send_frame(64'hA5_01_90_00_C8_00_64_3C);
    check("badsum.err",  32'(frame_err), 1);
    check("badsum.ok",   32'(frame_ok),  0);
    check("badsum.link", 32'(link_up),   1);
    check_xyp("badsum", 400, 200, 100);
    tick(1);
    check("badsum.err_pulse", 32'(frame_err), 0);

    // Leading garbage, then a frame whose payload contains A5 (x=0x1A5=421)
    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(64'hA5_01_A5_00_C8_00_64_08);
    check("a5data.ok", 32'(frame_ok), 1);
    check_xyp("a5data", 421, 200, 100);

    // All three coordinates exactly at their limits
    send_frame(64'hA5_02_76_01_D6_01_90_32);
    check("limit.ok", 32'(frame_ok), 1);
    check_xyp("limit", 630, 470, 400);

    // x = 631, correct checksum -> out of range
    send_frame(64'hA5_02_77_01_D6_01_90_33);
    check("xrange.err", 32'(frame_err), 1);
    check("xrange.x",   32'(x_ball_uart), 630);

    // p = 401 with x=400 y=200 -> out of range
    send_frame(64'hA5_01_90_00_C8_01_91_C9);
    check("prange.err", 32'(frame_err), 1);
    check("prange.p",   32'(y_player2_uart), 400);

    // Reserved bit set in B1, checksum correct
    send_frame(64'hA5_09_90_00_C8_00_64_35);
    check("rsv.err", 32'(frame_err), 1);
    check("rsv.ok",  32'(frame_ok),  0);
    check("rsv.x",   32'(x_ball_uart), 630);

    // Byte timeout: partial frame then 16 idle cycles
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h90);
    tick(15);
    check("bto.early", 32'(frame_err), 0);
    tick(1);
    check("bto.err", 32'(frame_err), 1);
    tick(1);
    send_frame(64'hA5_01_90_00_C8_00_64_3D);
    check("bto.recover", 32'(frame_ok), 1);
    check_xyp("bto", 400, 200, 100);

    // Link timeout: high for exactly 64 cycles after the commit
    tick(100);
    check("link.idle_low", 32'(link_up), 0);
    send_frame(64'hA5_01_90_00_C8_00_64_3D);
    check("link.rise", 32'(link_up), 1);
    tick(63);
    check("link.hold63", 32'(link_up), 1);
    tick(1);
    check("link.fall64", 32'(link_up), 0);

    // Rejected frames never raise the link
    send_frame(64'hA5_01_90_00_C8_00_64_3C);
    check("linkrej.err",  32'(frame_err), 1);
    check("linkrej.link", 32'(link_up),   0);
    send_frame(64'hA5_09_90_00_C8_00_64_35);
    tick(5);
    check("linkrej.link2", 32'(link_up), 0);

    // Reset after B4 of a valid frame
    send_frame(64'hA5_02_76_01_D6_01_90_32);
    check("rstmid.pre", 32'(x_ball_uart), 630);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h90);
    send_byte(8'h00);
    send_byte(8'hC8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_xyp("rstmid", 315, 235, 200);
    check("rstmid.ok",   32'(frame_ok),  0);
    check("rstmid.err",  32'(frame_err), 0);
    check("rstmid.link", 32'(link_up),   0);
    send_byte(8'h00);
    check("rsttail0.pulse", 32'({frame_ok, frame_err}), 0);
    send_byte(8'h64);
    check("rsttail1.pulse", 32'({frame_ok, frame_err}), 0);
    send_byte(8'h3D);
    check("rsttail2.pulse", 32'({frame_ok, frame_err}), 0);
    tick(1);
    check("rsttail3.pulse", 32'({frame_ok, frame_err}), 0);
    check_xyp("rsttail", 315, 235, 200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
